// File: rtl/vtg_pkg.sv
// vtg_pkg: shared types and default mode constants for video_timing_gen.
// Provides region enum, timing bundle struct and 1280x720p60 defaults.
package vtg_pkg;

    localparam int VTG_XW = 13;
    localparam int VTG_YW = 13;

    // Raster regions along one axis, in scan order.
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } region_e;

    typedef struct packed {
        logic [VTG_XW-1:0] h_total;
        logic [VTG_XW-1:0] h_active;
        logic [VTG_XW-1:0] h_sync_start;
        logic [VTG_XW-1:0] h_sync_end;
        logic [VTG_YW-1:0] v_total;
        logic [VTG_YW-1:0] v_active;
        logic [VTG_YW-1:0] v_sync_start;
        logic [VTG_YW-1:0] v_sync_end;
        logic              hs_pol;
        logic              vs_pol;
    } timing_t;

    localparam timing_t VTG_720P = '{
        h_total:      13'd1650,
        h_active:     13'd1280,
        h_sync_start: 13'd1390,
        h_sync_end:   13'd1430,
        v_total:      13'd750,
        v_active:     13'd720,
        v_sync_start: 13'd725,
        v_sync_end:   13'd730,
        hs_pol:       1'b1,
        vs_pol:       1'b1
    };

endpackage

// File: rtl/vtg_axis_counter.sv
// vtg_axis_counter: one raster axis (H or V) position counter with region decode.
// Ports: clk_in, reset, i_adv (step), i_total/i_active/i_sync_start/i_sync_end,
//        o_cnt (position), o_last (at total-1), o_sync (in sync span), o_region.
module vtg_axis_counter
    import vtg_pkg::*;
#(
    parameter int W = 13
) (
    input  logic         clk_in,
    input  logic         reset,
    input  logic         i_adv,
    input  logic [W-1:0] i_total,
    input  logic [W-1:0] i_active,
    input  logic [W-1:0] i_sync_start,
    input  logic [W-1:0] i_sync_end,
    output logic [W-1:0] o_cnt,
    output logic         o_last,
    output logic         o_sync,
    output region_e      o_region
);

    localparam logic [W-1:0] ONE = 1;

    logic [W-1:0] r_cnt;
    logic         w_last;
    logic         w_act;
    logic         w_sync;

    // total=0 wraps to all-ones, giving a full 2^W period.
    assign w_last = (r_cnt == (i_total - ONE));
    assign w_act  = (r_cnt < i_active);
    assign w_sync = (r_cnt >= i_sync_start) && (r_cnt < i_sync_end);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_adv) begin
            r_cnt <= w_last ? '0 : r_cnt + ONE;
        end
    end

    // Active takes precedence so data enable is never masked by a
    // misprogrammed sync span; sync itself is reported separately.
    always_comb begin
        o_region = BACK;
        if (w_act) begin
            o_region = ACTIVE;
        end else if (w_sync) begin
            o_region = SYNC;
        end else if (r_cnt < i_sync_start) begin
            o_region = FRONT;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = w_last;
    assign o_sync = w_sync;

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing source (x/y, H/V sync, DE, SOL/SOF strobes).
// Ports: clk_in, reset, ce, h_*/v_* timing, hs_pol/vs_pol -> x_out, y_out,
//        hn_out, vn_out, den_out, sol_out, sof_out. Timing is shadowed and
//        reloaded only at frame wrap. Optional VTG_INTERLACE_EN adds
//        interlace input and field_out output.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int X_BITS = 13,
    parameter int Y_BITS = 13
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              ce,
    input  logic [X_BITS-1:0] h_total,
    input  logic [X_BITS-1:0] h_active,
    input  logic [X_BITS-1:0] h_sync_start,
    input  logic [X_BITS-1:0] h_sync_end,
    input  logic [Y_BITS-1:0] v_total,
    input  logic [Y_BITS-1:0] v_active,
    input  logic [Y_BITS-1:0] v_sync_start,
    input  logic [Y_BITS-1:0] v_sync_end,
    input  logic              hs_pol,
    input  logic              vs_pol,
`ifdef VTG_INTERLACE_EN
    input  logic              interlace,
    output logic              field_out,
`endif
    output logic [X_BITS-1:0] x_out,
    output logic [Y_BITS-1:0] y_out,
    output logic              hn_out,
    output logic              vn_out,
    output logic              den_out,
    output logic              sol_out,
    output logic              sof_out
);

    logic [X_BITS-1:0] r_h_total_s;
    logic [X_BITS-1:0] r_h_active_s;
    logic [X_BITS-1:0] r_h_sync_start_s;
    logic [X_BITS-1:0] r_h_sync_end_s;
    logic [Y_BITS-1:0] r_v_total_s;
    logic [Y_BITS-1:0] r_v_active_s;
    logic [Y_BITS-1:0] r_v_sync_start_s;
    logic [Y_BITS-1:0] r_v_sync_end_s;
    logic              r_hs_pol_s;
    logic              r_vs_pol_s;

    logic [X_BITS-1:0] w_hc;
    logic [Y_BITS-1:0] w_vc;
    logic              w_h_last;
    logic              w_v_last;
    logic              w_h_sync;
    logic              w_v_sync;
    region_e           w_h_region;
    region_e           w_v_region;
    logic              w_v_adv;
    logic              w_frame_wrap;
    logic              w_vs;
    logic [Y_BITS-1:0] w_v_total;

    logic [X_BITS-1:0] r_x;
    logic [Y_BITS-1:0] r_y;
    logic              r_hn;
    logic              r_vn;
    logic              r_den;
    logic              r_sol;
    logic              r_sof;

    assign w_v_adv      = ce && w_h_last;
    assign w_frame_wrap = ce && w_h_last && w_v_last;

`ifdef VTG_INTERLACE_EN
    logic              r_interlace_s;
    logic              r_field;
    logic              r_field_out;
    logic [X_BITS-1:0] w_h_half;
    logic              w_h_ge_half;
    logic              w_vs_f1;

    // Field 1 carries one extra line; its vsync edges land mid-line.
    assign w_v_total   = r_v_total_s + Y_BITS'(r_field);
    assign w_h_half    = r_h_total_s >> 1;
    assign w_h_ge_half = (w_hc >= w_h_half);
    assign w_vs_f1 =
        ((w_vc > r_v_sync_start_s) ||
         ((w_vc == r_v_sync_start_s) && w_h_ge_half)) &&
        ((w_vc < r_v_sync_end_s) ||
         ((w_vc == r_v_sync_end_s) && !w_h_ge_half));
    assign w_vs = r_field ? w_vs_f1 : w_v_sync;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_interlace_s <= interlace;
            r_field       <= 1'b0;
            r_field_out   <= 1'b0;
        end else if (ce) begin
            r_field_out <= r_field;
            if (w_frame_wrap) begin
                r_interlace_s <= interlace;
                r_field       <= r_interlace_s ? ~r_field : 1'b0;
            end
        end
    end

    assign field_out = r_field_out;
`else
    assign w_v_total = r_v_total_s;
    assign w_vs      = w_v_sync;
`endif

    // Shadows reload on reset and at the last pixel of the frame, so the
    // new mode takes effect exactly as counters return to (0,0).
    always_ff @(posedge clk_in) begin
        if (reset || w_frame_wrap) begin
            r_h_total_s      <= h_total;
            r_h_active_s     <= h_active;
            r_h_sync_start_s <= h_sync_start;
            r_h_sync_end_s   <= h_sync_end;
            r_v_total_s      <= v_total;
            r_v_active_s     <= v_active;
            r_v_sync_start_s <= v_sync_start;
            r_v_sync_end_s   <= v_sync_end;
            r_hs_pol_s       <= hs_pol;
            r_vs_pol_s       <= vs_pol;
        end
    end

    vtg_axis_counter #(
        .W (X_BITS)
    ) u_h (
        .clk_in       (clk_in),
        .reset        (reset),
        .i_adv        (ce),
        .i_total      (r_h_total_s),
        .i_active     (r_h_active_s),
        .i_sync_start (r_h_sync_start_s),
        .i_sync_end   (r_h_sync_end_s),
        .o_cnt        (w_hc),
        .o_last       (w_h_last),
        .o_sync       (w_h_sync),
        .o_region     (w_h_region)
    );

    vtg_axis_counter #(
        .W (Y_BITS)
    ) u_v (
        .clk_in       (clk_in),
        .reset        (reset),
        .i_adv        (w_v_adv),
        .i_total      (w_v_total),
        .i_active     (r_v_active_s),
        .i_sync_start (r_v_sync_start_s),
        .i_sync_end   (r_v_sync_end_s),
        .o_cnt        (w_vc),
        .o_last       (w_v_last),
        .o_sync       (w_v_sync),
        .o_region     (w_v_region)
    );

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_x   <= '0;
            r_y   <= '0;
            r_hn  <= 1'b0;
            r_vn  <= 1'b0;
            r_den <= 1'b0;
            r_sol <= 1'b0;
            r_sof <= 1'b0;
        end else if (ce) begin
            r_x   <= w_hc;
            r_y   <= w_vc;
            r_hn  <= r_hs_pol_s ? w_h_sync : ~w_h_sync;
            r_vn  <= r_vs_pol_s ? w_vs : ~w_vs;
            r_den <= (w_h_region == ACTIVE) && (w_v_region == ACTIVE);
            r_sol <= (w_hc == '0);
            r_sof <= (w_hc == '0) && (w_vc == '0);
        end
    end

    assign x_out   = r_x;
    assign y_out   = r_y;
    assign hn_out  = r_hn;
    assign vn_out  = r_vn;
    assign den_out = r_den;
    assign sol_out = r_sol;
    assign sof_out = r_sof;

endmodule
